sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO: next-generation buffering primitive for the HDL library.
//   Width, depth, almost-full/empty thresholds and read mode are parameters.
//   Read mode is either registered read (1-cycle latency) or first-word-fall-through.
//   Sits between any producer/consumer pair in one clock domain; reports occupancy and
//   sticky-free error pulses for overflow/underflow.
// PARAMETERS
//   DATA_W    8          data word width, >=1
//   DEPTH     16         entries; power of 2, >=2
//   AF_LEVEL  DEPTH-2    almost_full asserted when count >= AF_LEVEL
//   AE_LEVEL  2          almost_empty asserted when count <= AE_LEVEL
//   FWFT      0          0 = registered read, 1 = first-word-fall-through
// PORTS
//   clk           in   1               rising-edge clock
//   rst_n         in   1               synchronous reset, active-low
//   wr_en         in   1               write request
//   wr_data       in   DATA_W          write word
//   full          out  1               count == DEPTH
//   almost_full   out  1               count >= AF_LEVEL
//   overflow      out  1               1-cycle pulse: wr_en rejected
//   rd_en         in   1               read/pop request
//   rd_data       out  DATA_W          read word
//   rd_valid      out  1               rd_data qualifier
//   empty         out  1               count == 0
//   almost_empty  out  1               count <= AE_LEVEL
//   underflow     out  1               1-cycle pulse: rd_en rejected
//   count         out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (rst_n==0 at posedge): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0,
//     overflow=underflow=0 -> empty=1, almost_empty=1, full=0, almost_full=0.
//     Storage array is NOT cleared; reset mid-operation discards all contents, and any
//     read in flight is dropped (rd_valid=0 the next cycle).
//   - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0; count held in a register.
//   - Write accepted iff wr_en && !full: mem[wr_ptr]<=wr_data, wr_ptr++.
//     Otherwise, if wr_en, overflow=1 the next cycle.
//   - Read accepted iff rd_en && !empty: rd_ptr++. Otherwise, if rd_en, underflow=1 the next cycle.
//   - Full/empty tests use the pre-edge count, so there is no pass-through: wr+rd while
//     empty -> write only (underflow); wr+rd while full -> read only (overflow).
//     wr+rd both accepted -> count unchanged.
//   - count += accepted_wr - accepted_rd each edge.
//   - Flags are combinational decodes of the count register only, with no input paths.
//   - FWFT=0: the accepted read at edge N gives rd_data=mem[old rd_ptr], rd_valid=1 after
//     edge N. With no accepted read, rd_valid=0 and rd_data holds its last value.
//   - FWFT=1: rd_data=mem[rd_ptr] (combinational), rd_valid=!empty, and rd_en pops the head.
//     A word written at edge N is visible after edge N (empty deasserts the same cycle count=1).
//   - Latency write->readable: 1 cycle (both modes); FWFT=0 adds 1 cycle for rd_data.
//   - Elaboration check: DEPTH not a power of 2, or AF_LEVEL/AE_LEVEL outside 0..DEPTH,
//     triggers $error.
// STRUCTURE
//   - Shared include fifo_defs.vh: CLOG2 macro, FIFO_MODE_REG=0 / FIFO_MODE_FWFT=1 constants.
//   - One sub-module: fifo_mem (DATA_W x DEPTH, 1 sync write port, 1 async read port).
//   - Top holds pointers, count, flag decode and the read-mode generate branch.
// TESTING
//   1 Reset: hold rst_n=0 for 2 cycles with wr_en=1 -> count=0, empty=1, almost_empty=1,
//     full=0, overflow=0.
//   2 Fill/drain (DEPTH=16, FWFT=0): write 0x00..0x0F -> full=1 after 16th edge,
//     almost_full from count=14; read 16 -> rd_data 0x00..0x0F in order, each one cycle
//     after rd_en.
//   3 Overflow/underflow: 17th write when full -> overflow pulse 1 cycle, count stays 16;
//     rd_en on empty -> underflow pulse, rd_valid=0.
//   4 Simultaneous: count=5 with wr+rd for 20 cycles -> count stays 5, order preserved
//     across pointer wrap; wr+rd at empty -> count=1, underflow=1.
//   5 FWFT=1: write 0xA5 at edge N -> rd_valid=1, rd_data=0xA5 after N;
//     rd_en pops -> empty=1 next cycle.
//   6 Reset mid-stream: count=9 with a read in flight, rst_n=0 one cycle -> count=0,
//     rd_valid=0; a new write reads back correctly.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param_pkg
// Description : Shared constants and elaboration helpers for sync_fifo_param.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_param_pkg;

  // Read-mode selector values for the FWFT parameter
  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // True when value is a power of two and at least 2
  function automatic bit is_pow2_f(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_param_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param_mem
// Description : DATA_W x DEPTH storage, one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store the word at the write address when enabled
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with registered or
//               first-word-fall-through read, occupancy count, almost
//               thresholds and one-cycle overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_MODE_REG
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   almost_empty,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = clog2_f(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE_CNT   = CW'(AE_LEVEL);

  // Parameter sanity checks, evaluated at elaboration
  if (!is_pow2_f(DEPTH)) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_LEVEL < 0) || (AF_LEVEL > DEPTH)) begin : g_chk_af
    $error("sync_fifo_param: AF_LEVEL outside 0..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH)) begin : g_chk_ae
    $error("sync_fifo_param: AE_LEVEL outside 0..DEPTH");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [DATA_W-1:0] w_head;

  // Acceptance uses the pre-edge count only, so an empty FIFO never passes a
  // same-cycle write through to the reader and a full one never absorbs a
  // write on the strength of a same-cycle read.
  assign w_wr_ok = wr_en && (count_q != C_FULL_CNT);
  assign w_rd_ok = rd_en && (count_q != '0);

  // Next-state for pointers, occupancy and error pulses
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en && !w_wr_ok;
    underflow_d = rd_en && !w_rd_ok;
    if (w_wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (w_wr_ok && !w_rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (w_rd_ok && !w_wr_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_param_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (w_wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_head)
  );

  // Flags decode the count register alone
  assign full         = (count_q == C_FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= C_AF_CNT);
  assign almost_empty = (count_q <= C_AE_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign count        = count_q;

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is presented directly; a pop simply advances the read pointer
    assign rd_data  = w_head;
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Capture the head on an accepted read; data holds otherwise
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= w_rd_ok;
        if (w_rd_ok) begin
          rd_data_q <= w_head;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule
`default_nettype wire
